// File: rtl/aes_engine.sv
// rtl/aes_engine.sv - AES-128 encryption engine, one round per clock
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   anahtar    128-bit cipher key, bits [127:120] are key byte 0
//   blok       128-bit plaintext block, bits [127:120] are state byte 0 (column-major)
//   g_gecerli  input valid, block accepted when g_gecerli and hazir are both 1
//   hazir      ready, 1 while idle
//   sifre      128-bit ciphertext, same byte ordering as blok
//   c_gecerli  one-cycle pulse marking a new sifre value
//
// Configuration macro: AES_ENGINE_OUTPUT_HOLD_EN
//   defined   : sifre keeps the last ciphertext until the next completion or reset
//   undefined : sifre carries the ciphertext only during the c_gecerli cycle, else 0

module aes_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] blok,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] sifre,
    output logic         c_gecerli
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       st;
    logic [127:0] aes_st;
    logic [127:0] rkey;
    logic [3:0]   rnd;

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mx [16];
    logic [127:0] next_key;
    logic [127:0] round_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply), then the affine map.
    // Zero maps to zero naturally because 0^254 = 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Key expansion for the round about to execute: rkey holds the previous round key.
    always_comb begin
        logic [31:0] w3;
        logic [31:0] tmp;
        logic [31:0] n0, n1, n2, n3;
        w3  = rkey[31:0];
        tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon(rnd), 24'h000000};
        n0  = rkey[127:96] ^ tmp;
        n1  = rkey[95:64]  ^ n0;
        n2  = rkey[63:32]  ^ n1;
        n3  = rkey[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Byte i of the state is row (i % 4), column (i / 4).
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        round_out = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(aes_st[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r+4*((c+r)%4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mx[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mx[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mx[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mx[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        // The last round skips MixColumns.
        for (int i = 0; i < 16; i++) begin
            round_out[127-8*i -: 8] = (rnd == 4'd10) ? sr[i] : mx[i];
        end
        round_out = round_out ^ next_key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            hazir     <= 1'b1;
            c_gecerli <= 1'b0;
            sifre     <= '0;
            rnd       <= 4'd0;
            aes_st    <= '0;
            rkey      <= '0;
        end else begin
            c_gecerli <= 1'b0;
`ifndef AES_ENGINE_OUTPUT_HOLD_EN
            sifre     <= '0;
`endif
            case (st)
                IDLE: begin
                    if (g_gecerli) begin
                        aes_st <= blok ^ anahtar;
                        rkey   <= anahtar;
                        rnd    <= 4'd1;
                        st     <= RUN;
                        hazir  <= 1'b0;
                    end
                end
                RUN: begin
                    aes_st <= round_out;
                    rkey   <= next_key;
                    if (rnd == 4'd10) begin
                        st        <= IDLE;
                        hazir     <= 1'b1;
                        c_gecerli <= 1'b1;
                        sifre     <= round_out;
                        rnd       <= 4'd0;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: begin
                    st    <= IDLE;
                    hazir <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_engine.sv
// tb/tb_aes_engine.sv - scoreboard testbench for aes_engine with a reference AES model

module tb_aes_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] anahtar;
    logic [127:0] blok;
    logic         g_gecerli;
    logic         hazir;
    logic [127:0] sifre;
    logic         c_gecerli;

    always #5 clk = ~clk;

    aes_engine dut (
        .clk       (clk),
        .rst       (rst),
        .anahtar   (anahtar),
        .blok      (blok),
        .g_gecerli (g_gecerli),
        .hazir     (hazir),
        .sifre     (sifre),
        .c_gecerli (c_gecerli)
    );

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        logic [127:0] val;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [7:0]   sbox_t [256];
    bit           known_flag = 1'b0;
    logic [127:0] known_val = '0;
    bit           spacing_on = 1'b0;
    int           last_acc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box built by brute-force inverse search plus the bitwise affine formula.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            logic [7:0] cst;
            inv = 0;
            cst = 8'h63;
            for (int y = 1; y < 256; y++)
                if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbox_t[x] = s;
        end
    end

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] blk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) t[r] = s[4*c+r];
                    s[4*c]   = gm(t[0], 2) ^ gm(t[1], 3) ^ t[2] ^ t[3];
                    s[4*c+1] = t[0] ^ gm(t[1], 2) ^ gm(t[2], 3) ^ t[3];
                    s[4*c+2] = t[0] ^ t[1] ^ gm(t[2], 2) ^ gm(t[3], 3);
                    s[4*c+3] = gm(t[0], 3) ^ t[1] ^ t[2] ^ gm(t[3], 2);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] ^= w[4*rd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // Accept detector: a block is taken at the coming edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && g_gecerli && hazir) begin
            exp_t e;
            e.val = known_flag ? known_val : aes_ref(anahtar, blok);
            e.due = cyc + 11;
            sb_q.push_back(e);
            if (spacing_on && last_acc >= 0) check("accept_spacing", cyc - last_acc, 11);
            last_acc = cyc;
        end
    end

    // Monitor: pops expectations on each output pulse and checks the cycle after it.
    bit           prev_c = 1'b0;
    logic         rst_q = 1'b1;
    logic [127:0] last_val = '0;
    always @(negedge clk) begin
        if (c_gecerli === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_c_gecerli: got pulse required none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("latency", cyc, e.due);
                check("sifre", sifre, e.val);
            end
            last_val = sifre;
        end else if (prev_c && !rst_q) begin
`ifdef AES_ENGINE_OUTPUT_HOLD_EN
            check("sifre_after_pulse", sifre, last_val);
`else
            check("sifre_after_pulse", sifre, 128'h0);
`endif
        end
        prev_c = (c_gecerli === 1'b1);
        rst_q  = rst;
    end

    // Busy-window length: hazir must stay low for exactly 10 cycles per unaborted block.
    int run_len = 0;
    bit aborted = 1'b0;
    always @(negedge clk) begin
        if (hazir === 1'b0) begin
            run_len++;
            if (rst) aborted = 1'b1;
        end else begin
            if (run_len > 0 && !aborted) check("busy_cycles", run_len, 10);
            run_len = 0;
            aborted = 1'b0;
        end
    end

    task automatic send(input logic [127:0] k, input logic [127:0] b,
                        input bit kn, input logic [127:0] kv);
        int n;
        anahtar    = k;
        blok       = b;
        known_flag = kn;
        known_val  = kv;
        g_gecerli  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!hazir && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!hazir) begin
            total++;
            bad++;
            $display("FAIL send_timeout: hazir got %b required 1", hazir);
        end
        @(posedge clk);
        #1 g_gecerli = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending got %0d required 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        g_gecerli = 1'b0;
        anahtar   = '0;
        blok      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hazir", hazir, 1);
        check("reset_c_gecerli", c_gecerli, 0);
        check("reset_sifre", sifre, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // First accept at the first edge after reset release.
        send(K1, P1, 1'b1, C1);
        @(negedge clk);
        check("accept_first_edge", hazir, 0);
        drain();

        send(K2, P2, 1'b1, C2);
        drain();

        // Inputs changing during RUN must not disturb the result.
        send(K1, P1, 1'b1, C1);
        anahtar = K2;
        blok    = P2;
        drain();

        // Valid held high: accepts every 11 cycles, identical results.
        anahtar    = K1;
        blok       = P1;
        known_flag = 1'b1;
        known_val  = C1;
        last_acc   = -1;
        spacing_on = 1'b1;
        g_gecerli  = 1'b1;
        repeat (33) @(posedge clk);
        #1 g_gecerli = 1'b0;
        spacing_on = 1'b0;
        drain();

        // Reset during round 5 aborts; the engine then works normally.
        send(K1, P1, 1'b1, C1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_hazir", hazir, 1);
        check("abort_sifre", sifre, 0);
        check("abort_c_gecerli", c_gecerli, 0);
        @(posedge clk);
        #1;
        send(K2, P2, 1'b1, C2);
        drain();

        // Random blocks against the reference model.
        for (int i = 0; i < 20; i++) begin
            logic [127:0] k;
            logic [127:0] b;
            int gap;
            k = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            send(k, b, 1'b0, 128'h0);
            gap = $urandom_range(0, 14);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
